// File: rtl/apb_pkg.sv
// Shared APB definitions: bus phase encoding, response codes and counter sizing.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  // Bits needed to count 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    if (n == 32'd0) begin
      w = 32'd1;
    end else begin
      w = $clog2(n + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Access-phase wait-state generator: holds PREADY low for WAIT_CYCLES cycles of
// every access phase, and tracks the APB phase seen at the previous edge.
module apb_wait_gen
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic PSEL,
  input  logic PENABLE,
  output logic ready
);

  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  apb_phase_e       state_r;
  apb_phase_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             access_s;
  logic             ready_s;

  assign access_s = PSEL & PENABLE;

  // Phase register and wait counter; the counter restarts for every access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (access_s && !ready_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP:  state_s = ACCESS;
      ACCESS: begin
        if (!PSEL) begin
          state_s = IDLE;
        end else if (!PENABLE) begin
          state_s = SETUP;
        end else begin
          state_s = ACCESS;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Gated by PRESETn so an asserted reset drops ready in the same cycle.
  always_comb begin
    ready_s = 1'b0;
    if (PRESETn && access_s && (cnt_r == CNT_LAST)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign ready = ready_s;

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with wait states, byte strobes and an
// out-of-range error response. Memory contents are not reset.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              ready_s;
  logic              in_range_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] rdata_s;

  apb_wait_gen #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_gen (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .ready  (ready_s)
  );

  // Full PADDR takes part in the range check, so no address ever aliases.
  assign in_range_s = ({1'b0, PADDR} < DEPTH_C);
  assign idx_s      = PADDR[IDX_W-1:0];
  assign wr_en_s    = ready_s & PWRITE & in_range_s;

  always_ff @(posedge PCLK) begin
    if (wr_en_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (PSTRB[i]) begin
          mem_r[idx_s][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_s = '0;
    if (PRESETn && PSEL && PENABLE && !PWRITE && in_range_s) begin
      rdata_s = mem_r[idx_s];
    end else begin
      rdata_s = '0;
    end
  end

  assign PRDATA  = rdata_s;
  assign PREADY  = ready_s;
  assign PSLVERR = (ready_s && !in_range_s) ? ERROR : OKAY;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Three slaves (WAIT_CYCLES 0/3/2) on one bus; driver pushes expected responses,
// a monitor compares them whenever the selected slave raises PREADY.
module tb_apb_mem_slave;

  localparam int NS  = 3;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [NS-1:0] psel = '0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [3:0]    PSTRB = '0;
  logic [DW-1:0] prdata [NS];
  logic [NS-1:0] pready;
  logic [NS-1:0] pslverr;

  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < NS; g++) begin : g_dut
    apb_mem_slave #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[g]), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  int          acc = 0;
  logic [31:0] model [NS][DEP];

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 3 : 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts not-ready access cycles and pops one expectation per completion.
  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn && (psel != '0) && PENABLE) begin
        if (pready[cur]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual=1 required=0 slave=%0d", cur);
          end else begin
            mon_e = q.pop_front();
            check({mon_e.name, "_prdata"}, prdata[cur], mon_e.rdata);
            check({mon_e.name, "_pslverr"}, {31'b0, pslverr[cur]}, {31'b0, mon_e.err});
            check({mon_e.name, "_waits"}, acc, mon_e.waits);
          end
          acc = 0;
        end else begin
          acc++;
        end
      end else begin
        acc = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (i != cur) check("unselected_pready", {31'b0, pready[i]}, 32'd0);
      end
    end
  end

  task automatic setup(input int s, input bit wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] st);
    cur = s;
    psel = '0;
    psel[s] = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = a;
    PWDATA = d;
    PSTRB = st;
    @(posedge PCLK);
    #1 PENABLE = 1'b1;
  endtask

  task automatic idle();
    psel = '0;
    PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  task automatic xfer(input int s, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] st, input string nm);
    exp_t        e;
    logic [31:0] m;
    bit          done;
    e.err   = (a >= DEP);
    e.waits = wait_of(s);
    e.name  = nm;
    if (wr) begin
      e.rdata = 32'd0;
      m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
      if (!e.err) model[s][a] = (model[s][a] & ~m) | (d & m);
    end else begin
      e.rdata = e.err ? 32'd0 : model[s][a];
    end
    q.push_back(e);
    setup(s, wr, a, d, st);
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge PCLK);
      done = pready[s];
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_pready required=pready", nm);
    end
    @(posedge PCLK);
    #1 PENABLE = 1'b0;
  endtask

  task automatic check_quiet(input int s, input string nm);
    check({nm, "_pready"}, {31'b0, pready[s]}, 32'd0);
    check({nm, "_pslverr"}, {31'b0, pslverr[s]}, 32'd0);
    check({nm, "_prdata"}, prdata[s], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a;
    #1;
    for (int s = 0; s < NS; s++) check_quiet(s, "reset");
    @(posedge PCLK);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idle();

    for (int s = 0; s < NS; s++)
      for (int i = 0; i < DEP; i++) xfer(s, 1'b1, 8'(i), $urandom, 4'hF, "fill");
    idle();

    xfer(0, 1'b1, 8'd3, 32'hDEADBEEF, 4'hF, "t1_wr");
    idle();
    xfer(0, 1'b0, 8'd3, 32'd0, 4'hF, "t1_rd");
    xfer(1, 1'b1, 8'd3, 32'hDEADBEEF, 4'hF, "t2_wr");
    idle();
    xfer(1, 1'b0, 8'd3, 32'd0, 4'h0, "t2_rd");
    idle();
    xfer(0, 1'b1, 8'd3, 32'h11223344, 4'b0101, "t3_wr");
    xfer(0, 1'b0, 8'd3, 32'd0, 4'h0, "t3_rd");
    xfer(0, 1'b1, 8'd20, 32'hA5A5A5A5, 4'hF, "t4_wr");
    xfer(0, 1'b0, 8'd20, 32'd0, 4'hF, "t4_rd");
    xfer(0, 1'b0, 8'd4, 32'd0, 4'hF, "t4_alias");
    idle();

    // Abort: PSEL dropped after one wait cycle.
    setup(1, 1'b1, 8'd5, 32'h55, 4'hF);
    @(negedge PCLK);
    check("t5_abort_wait", {31'b0, pready[1]}, 32'd0);
    @(posedge PCLK);
    #1 idle();
    xfer(1, 1'b0, 8'd5, 32'd0, 4'hF, "t5_abort_rd");
    idle();

    // Reset during a wait cycle.
    setup(1, 1'b1, 8'd5, 32'h55, 4'hF);
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1 check_quiet(1, "t5_rst_wait");
    psel = '0;
    PENABLE = 1'b0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idle();
    xfer(1, 1'b0, 8'd5, 32'd0, 4'hF, "t5_rst_rd");
    idle();

    // Reset while a zero-wait slave is already ready.
    setup(0, 1'b1, 8'd5, 32'h55, 4'hF);
    #1 check("t5_pre_rst_ready", {31'b0, pready[0]}, 32'd1);
    PRESETn = 1'b0;
    #1 check_quiet(0, "t5_rst_ready");
    @(posedge PCLK);
    #1 psel = '0;
    PENABLE = 1'b0;
    PRESETn = 1'b1;
    idle();
    xfer(0, 1'b0, 8'd5, 32'd0, 4'hF, "t5_rst0_rd");
    idle();

    xfer(2, 1'b1, 8'd0, $urandom, 4'hF, "t6_wr");
    xfer(2, 1'b0, 8'd0, 32'd0, 4'hF, "t6_rd");
    idle();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(16, 255));
      else a = 8'($urandom_range(0, 15));
      xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)), "rand");
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    idle();
    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
